// File: rtl/count_seq_checker.sv
// count_seq_checker
//
// Monitors a 3-bit synchronous down counter through its true/complement rails.
// It checks that the rails are complementary and that the count follows the
// modulo-8 decrement sequence. It acquires lock after a run of good steps. Once
// locked it reports terminal-count pulses, keeps a saturating count of 0->7
// wraps, and raises sticky error flags.
//
// Parameters
//   WRAP_W    width of wrap_cnt
//   LOCK_N    consecutive good steps needed for lock (1..7)
//
// Ports
//   clk       rising-edge clock, shared with the counter
//   rst       synchronous active-high reset
//   en        sample strobe; q/qbar are evaluated only when en=1
//   clr       clears sticky errors and wrap_cnt, and forces re-acquisition
//   q, qbar   counter true and complement outputs
//   locked    high while tracking
//   tc        one-cycle pulse after a tracked sample with q=0
//   wrap_cnt  saturating count of 0->7 wraps seen while tracking
//   err_compl sticky: a sample had q != ~qbar
//   err_seq   sticky: a tracked sample was not previous-1 mod 8
module count_seq_checker #(
  parameter int unsigned WRAP_W = 8,
  parameter int unsigned LOCK_N = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [2:0]        q,
  input  logic [2:0]        qbar,
  output logic              locked,
  output logic              tc,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err_compl,
  output logic              err_seq
);

  typedef enum logic [1:0] {StAcq, StTrack, StFault} state_e;

  state_e     state_q;
  logic [2:0] prev_q;
  logic       prev_valid_q;
  logic [2:0] good_q;

  logic       compl_ok;
  logic       step_ok;
  logic       wrap_hit;
  logic [2:0] good_inc;

  assign compl_ok = (q == ~qbar);
  // 0 -> 7 is a legal step because the subtraction wraps in 3 bits.
  assign step_ok  = prev_valid_q && (q == prev_q - 3'd1);
  assign wrap_hit = (prev_q == 3'd0) && (q == 3'd7);
  assign good_inc = good_q + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StAcq;
      prev_q       <= 3'd0;
      prev_valid_q <= 1'b0;
      good_q       <= 3'd0;
      locked       <= 1'b0;
      tc           <= 1'b0;
      wrap_cnt     <= '0;
      err_compl    <= 1'b0;
      err_seq      <= 1'b0;
    end else if (clr) begin
      // The sample on this edge is discarded, so clr wins over any error or wrap.
      state_q      <= StAcq;
      prev_valid_q <= 1'b0;
      good_q       <= 3'd0;
      locked       <= 1'b0;
      tc           <= 1'b0;
      wrap_cnt     <= '0;
      err_compl    <= 1'b0;
      err_seq      <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (en) begin
        unique case (state_q)
          StAcq: begin
            if (!compl_ok) begin
              err_compl    <= 1'b1;
              good_q       <= 3'd0;
              prev_valid_q <= 1'b0;
            end else begin
              prev_q       <= q;
              prev_valid_q <= 1'b1;
              // The counter holds 0 during its reset, so repeats and skips here only
              // restart the good-step run. They are not errors.
              if (step_ok) begin
                good_q <= good_inc;
                if (good_inc == 3'(LOCK_N)) begin
                  state_q <= StTrack;
                  locked  <= 1'b1;
                end
              end else begin
                good_q <= 3'd0;
              end
            end
          end

          StTrack: begin
            if (!compl_ok || !step_ok) begin
              // A complement error and a sequence error on the same sample set both flags.
              if (!compl_ok) begin
                err_compl <= 1'b1;
              end
              if (!step_ok) begin
                err_seq <= 1'b1;
              end
              state_q <= StFault;
              locked  <= 1'b0;
            end else begin
              prev_q <= q;
              if (wrap_hit && (wrap_cnt != {WRAP_W{1'b1}})) begin
                wrap_cnt <= wrap_cnt + 1'b1;
              end
              if (q == 3'd0) begin
                tc <= 1'b1;
              end
            end
          end

          default: begin
            // StFault: samples are ignored until clr or rst.
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_count_seq_checker.sv
// Bench for count_seq_checker. A driver process applies one directed vector per
// cycle and queues the expected outputs for that edge. A monitor process pops
// the queue just after each rising edge and compares. A second instance with
// WRAP_W=2 checks wrap-counter saturation.
module tb_count_seq_checker;

  localparam int unsigned LOCK_N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, clr;
  logic [2:0] q, qbar;
  logic       locked, tc, err_compl, err_seq;
  logic [7:0] wrap_cnt;

  logic       rst2;
  logic [2:0] q2, qbar2;
  logic       locked2, tc2, err_compl2, err_seq2;
  logic [1:0] wrap_cnt2;

  assign qbar2 = ~q2;

  count_seq_checker #(.WRAP_W(8), .LOCK_N(LOCK_N)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clr       (clr),
    .q         (q),
    .qbar      (qbar),
    .locked    (locked),
    .tc        (tc),
    .wrap_cnt  (wrap_cnt),
    .err_compl (err_compl),
    .err_seq   (err_seq)
  );

  count_seq_checker #(.WRAP_W(2), .LOCK_N(LOCK_N)) dut2 (
    .clk       (clk),
    .rst       (rst2),
    .en        (1'b1),
    .clr       (1'b0),
    .q         (q2),
    .qbar      (qbar2),
    .locked    (locked2),
    .tc        (tc2),
    .wrap_cnt  (wrap_cnt2),
    .err_compl (err_compl2),
    .err_seq   (err_seq2)
  );

  // exp packs {locked, tc, wrap_cnt[7:0], err_compl, err_seq}; for dut2 only exp[1:0] is used.
  typedef struct {
    bit          u2;
    bit          chk;
    logic [11:0] exp;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Expected outputs after the next edge, plus the bench's view of progress.
  logic       e_lk, e_tc, e_ec, e_es;
  logic [7:0] e_wr;
  int         acq_k;
  bit         fault;
  logic [2:0] pv, cnt, c2;

  task automatic drive(input logic [2:0] qv, input logic [2:0] qbv, input logic env,
                       input logic clrv, input logic rstv, input string nm);
    exp_t e;
    @(negedge clk);
    q = qv; qbar = qbv; en = env; clr = clrv; rst = rstv;
    e.u2 = 1'b0; e.chk = 1'b1; e.exp = {e_lk, e_tc, e_wr, e_ec, e_es}; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic drive2(input logic [2:0] v, input logic rstv, input bit chk,
                        input logic [1:0] wexp, input string nm);
    exp_t e;
    @(negedge clk);
    q2 = v; rst2 = rstv;
    e.u2 = 1'b1; e.chk = chk; e.exp = {10'd0, wexp}; e.nm = nm;
    sb.push_back(e);
  endtask

  // Good sample v with en=1. Lock comes after sample LOCK_N of a run, counted from 0;
  // later samples are tracked.
  task automatic sample(input logic [2:0] v, input string nm);
    bit trk;
    if (fault) begin
      e_tc = 1'b0;
    end else begin
      trk  = (acq_k >= int'(LOCK_N) + 1);
      e_tc = trk && (v == 3'd0);
      if (trk && pv == 3'd0 && v == 3'd7 && e_wr != 8'hff) e_wr = e_wr + 8'd1;
      e_lk  = (acq_k >= int'(LOCK_N));
      acq_k = acq_k + 1;
      pv    = v;
    end
    drive(v, ~v, 1'b1, 1'b0, 1'b0, nm);
  endtask

  task automatic free_one(input string nm);
    sample(cnt, nm);
    cnt = cnt - 3'd1;
  endtask

  task automatic gap(input logic [2:0] v, input string nm);
    e_tc = 1'b0;
    drive(v, ~v, 1'b0, 1'b0, 1'b0, nm);
  endtask

  task automatic clear_exp();
    e_lk = 1'b0; e_tc = 1'b0; e_wr = 8'd0; e_ec = 1'b0; e_es = 1'b0;
    fault = 1'b0; acq_k = 0;
  endtask

  // Monitor: compares each edge's outputs against the queued expectation.
  always @(posedge clk) begin : mon
    exp_t        e;
    logic [11:0] act;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.chk) begin
        checks++;
        if (e.u2) begin
          act = {10'd0, wrap_cnt2};
          if (act !== e.exp) begin
            errors++;
            $display("FAIL %s: got wrap_cnt=%0d expected %0d", e.nm, act[1:0], e.exp[1:0]);
          end
        end else begin
          act = {locked, tc, wrap_cnt, err_compl, err_seq};
          if (act !== e.exp) begin
            errors++;
            $display("FAIL %s: got locked=%b tc=%b wrap=%0d ec=%b es=%b, expected locked=%b tc=%b wrap=%0d ec=%b es=%b",
                     e.nm, act[11], act[10], act[9:2], act[1], act[0],
                     e.exp[11], e.exp[10], e.exp[9:2], e.exp[1], e.exp[0]);
          end
        end
      end
    end
  end

  int exp_wraps[6] = '{1, 2, 3, 3, 3, 3};

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; q = 3'd0; qbar = 3'd7;
    rst2 = 1'b1; q2 = 3'd0;
    pv = 3'd0; cnt = 3'd0; c2 = 3'd0;
    clear_exp();

    // Reset: the counter presents 0 during reset.
    repeat (3) drive(3'd0, 3'd7, 1'b1, 1'b0, 1'b1, "reset");

    // Release together and free-run: 0,7,6,5 locks; tc on q=0; wraps on 0->7.
    clear_exp();
    repeat (100) free_one("free_run");

    // Complement error in TRACK, held through 20 cycles of FAULT, then clr and relock.
    while (cnt != 3'd5) free_one("to_5");
    e_lk = 1'b0; e_tc = 1'b0; e_ec = 1'b1; fault = 1'b1;
    drive(3'd5, 3'd0, 1'b1, 1'b0, 1'b0, "compl_err");
    cnt = cnt - 3'd1;
    repeat (20) free_one("compl_hold");
    clear_exp();
    drive(cnt, ~cnt, 1'b1, 1'b1, 1'b0, "clr_after_compl");
    cnt = cnt - 3'd1;
    repeat (4) free_one("relock");

    // Sequence 6,5,3 in TRACK: err_seq only, wrap_cnt frozen afterwards.
    repeat (16) free_one("track");
    while (cnt != 3'd6) free_one("to_6");
    free_one("seq_6");
    free_one("seq_5");
    e_lk = 1'b0; e_tc = 1'b0; e_es = 1'b1; fault = 1'b1;
    drive(3'd3, 3'd4, 1'b1, 1'b0, 1'b0, "seq_err");
    cnt = cnt - 3'd1;
    repeat (10) free_one("seq_frozen");
    clear_exp();
    drive(cnt, ~cnt, 1'b1, 1'b1, 1'b0, "clr_after_seq");
    cnt = cnt - 3'd1;

    // clr on the same edge as a complement error: clr wins and the checker goes to ACQ,
    // which the relock after LOCK_N+1 samples confirms.
    repeat (8) free_one("relock2");
    clear_exp();
    drive(cnt, cnt, 1'b1, 1'b1, 1'b0, "clr_vs_compl");
    cnt = cnt - 3'd1;
    repeat (5) free_one("acq_after_clr");

    // en gaps while the counter stalls: 4, gap, gap, 3 is fine.
    while (cnt != 3'd4) free_one("to_4");
    free_one("en_4");
    gap(3'd4, "gap_4");
    gap(3'd4, "gap_4");
    free_one("en_3");
    // tc pulses once and stays low through the gaps.
    while (cnt != 3'd0) free_one("to_0");
    free_one("en_0");
    gap(3'd0, "gap_0");
    gap(3'd0, "gap_0");
    free_one("en_7_wrap");
    // 4, gap, gap, 1 is a sequence error.
    while (cnt != 3'd4) free_one("to_4b");
    free_one("en_4b");
    gap(3'd4, "gap_4b");
    gap(3'd4, "gap_4b");
    e_lk = 1'b0; e_tc = 1'b0; e_es = 1'b1; fault = 1'b1;
    drive(3'd1, 3'd6, 1'b1, 1'b0, 1'b0, "skip_err");
    repeat (2) free_one("skip_hold");

    // WRAP_W=2 instance: wrap_cnt reads 1,2,3,3,3,3 after successive wraps.
    drive2(3'd0, 1'b1, 1'b1, 2'd0, "reset2");
    c2 = 3'd0;
    for (int k = 0; k < 50; k++) begin
      if (k >= 9 && ((k - 9) % 8) == 0)
        drive2(c2, 1'b0, 1'b1, 2'(exp_wraps[(k - 9) / 8]), "wrap2");
      else
        drive2(c2, 1'b0, 1'b0, 2'd0, "wrap2");
      c2 = c2 - 3'd1;
    end

    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending entries expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
